// File: rtl/SdramArbTypes.sv
// Shared types and constants for the SDRAM port arbiter.
package SdramArbTypes;

   typedef enum logic [2:0] {
      WAIT_INIT,
      IDLE,
      WR_BURST,
      RD_CMD,
      RD_WAIT,
      GAP,
      FAULT
   } arb_state_t;

   localparam logic MEM_CMD_WRITE = 1'b1;
   localparam logic MEM_CMD_READ  = 1'b0;

   // Width of a counter that holds the values 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sdram_arb_picker.sv
// Request sampling and read-priority choice with a write starvation guard.
// The choice is offered combinationally while the arbiter sits in IDLE and
// is also kept as a registered grant select for the burst that follows.
module sdram_arb_picker
   import SdramArbTypes::*;
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic clk,
   input  logic reset_n,
   input  logic sample_i,   // arbiter is in IDLE and may take a request
   input  logic wr_req_i,
   input  logic rd_req_i,
   output logic go_o,       // a request is taken this cycle
   output logic pick_wr_o,  // the request taken this cycle is the write
   output logic sel_wr_o    // registered grant select: 1 = write burst
);

   localparam int SW = cnt_width(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q, starve_d;
   logic          sel_wr_q, sel_wr_d;
   logic          starved;

   // Choose read first unless the write has already lost STARVE_LIMIT times.
   always_comb begin
      starved   = (starve_q == SW'(STARVE_LIMIT));
      go_o      = sample_i & (wr_req_i | rd_req_i);
      pick_wr_o = wr_req_i & (~rd_req_i | starved);
      sel_wr_d  = sel_wr_q;
      starve_d  = starve_q;
      if (go_o) begin
         sel_wr_d = pick_wr_o;
         if (pick_wr_o) begin
            starve_d = '0;
         end else if (wr_req_i && !starved) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   // Starve counter and grant select registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= '0;
         sel_wr_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         sel_wr_q <= sel_wr_d;
      end
   end

   assign sel_wr_o = sel_wr_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller user port between the frame uploader (writes)
// and the display reader (reads): fixed-length bursts, an idle gap after each
// burst, read-beat timeout and stray-beat detection.
module sdram_port_arbiter
   import SdramArbTypes::*;
#(
   parameter int ADDR_WIDTH   = 21,
   parameter int DATA_WIDTH   = 32,
   parameter int BURST_BEATS  = 8,
   parameter int GAP_CYCLES   = 2,
   parameter int RD_TIMEOUT   = 64,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    init_done,
   input  logic                    wr_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_data_next,
   output logic                    wr_grant,
   output logic                    wr_done,
   input  logic                    rd_req,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rd_grant,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    rd_data_valid_o,
   output logic                    rd_done,
   output logic                    mem_cmd,
   output logic                    mem_cmd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   output logic [DATA_WIDTH/8-1:0] mem_data_mask,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data,
   input  logic                    mem_rd_data_valid,
   output logic                    error
);

   localparam int BW = cnt_width(BURST_BEATS);
   localparam int GW = cnt_width(GAP_CYCLES);
   localparam int TW = cnt_width(RD_TIMEOUT);

   arb_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BW-1:0]         beat_q, beat_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  error_q, error_d;
   logic                  go, pick_wr, sel_wr;
   logic                  last_beat;
   logic                  in_rd_wait;

   sdram_arb_picker #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_picker (
      .clk       (clk),
      .reset_n   (reset_n),
      .sample_i  (state_q == IDLE),
      .wr_req_i  (wr_req),
      .rd_req_i  (rd_req),
      .go_o      (go),
      .pick_wr_o (pick_wr),
      .sel_wr_o  (sel_wr)
   );

   assign last_beat  = (beat_q == BW'(BURST_BEATS - 1));
   assign in_rd_wait = (state_q == RD_WAIT);

   // Burst sequencing, gap timing, read timeout and sticky error.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      tmo_d   = tmo_q;
      error_d = error_q;
      // A beat nobody asked for is dropped but remembered as a fault.
      if (mem_rd_data_valid && !in_rd_wait) error_d = 1'b1;
      case (state_q)
         WAIT_INIT: if (init_done) state_d = IDLE;
         IDLE: begin
            if (go) begin
               addr_d  = pick_wr ? wr_addr : rd_addr;
               beat_d  = '0;
               state_d = pick_wr ? WR_BURST : RD_CMD;
            end
         end
         WR_BURST: begin
            beat_d = beat_q + 1'b1;
            if (last_beat) begin
               beat_d  = '0;
               gap_d   = '0;
               state_d = GAP;
            end
         end
         RD_CMD: begin
            tmo_d   = '0;
            beat_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rd_data_valid) begin
               tmo_d  = '0;
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  gap_d   = '0;
                  state_d = GAP;
               end
            end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = FAULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               gap_d   = '0;
               state_d = IDLE;
            end
         end
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
   end

   // State and counter registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_INIT;
         addr_q  <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end

   // Port outputs decoded from the current state; zero outside a burst.
   always_comb begin
      wr_grant        = (state_q == WR_BURST);
      wr_data_next    = wr_grant;
      wr_done         = wr_grant & last_beat;
      mem_wr_data     = wr_grant ? wr_data : '0;
      rd_grant        = (state_q == RD_CMD) || in_rd_wait;
      rd_data_valid_o = in_rd_wait & mem_rd_data_valid;
      rd_data_o       = in_rd_wait ? mem_rd_data : '0;
      rd_done         = rd_data_valid_o & last_beat;
      mem_cmd_en      = (state_q == RD_CMD) || (wr_grant && beat_q == '0);
      mem_cmd         = MEM_CMD_READ;
      mem_addr        = '0;
      if (wr_grant || rd_grant) begin
         mem_cmd  = sel_wr ? MEM_CMD_WRITE : MEM_CMD_READ;
         mem_addr = addr_q;
      end
      mem_data_mask   = '0;
      error           = error_q;
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed sequences, an
// arbitration vector table and randomized bursts against a transaction model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

   localparam int AW    = 21;
   localparam int DW    = 32;
   localparam int BEATS = 8;
   localparam int GAPC  = 2;
   localparam int SLIM  = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          init_done = 1'b0;
   logic          wr_req = 1'b0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] mem_rd_data = '0;
   logic          mem_rd_data_valid = 1'b0;

   logic          wr_data_next, wr_grant, wr_done;
   logic          rd_grant, rd_data_valid_o, rd_done;
   logic [DW-1:0] rd_data_o, mem_wr_data;
   logic          mem_cmd, mem_cmd_en, error;
   logic [AW-1:0] mem_addr;
   logic [DW/8-1:0] mem_data_mask;

   int checks = 0;
   int failures = 0;
   int starve_m = 0;   // model: read grants taken while a write waited
   int txn_no = 0;

   always #5 clk = ~clk;

   sdram_port_arbiter dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .init_done         (init_done),
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_data_next      (wr_data_next),
      .wr_grant          (wr_grant),
      .wr_done           (wr_done),
      .rd_req            (rd_req),
      .rd_addr           (rd_addr),
      .rd_grant          (rd_grant),
      .rd_data_o         (rd_data_o),
      .rd_data_valid_o   (rd_data_valid_o),
      .rd_done           (rd_done),
      .mem_cmd           (mem_cmd),
      .mem_cmd_en        (mem_cmd_en),
      .mem_addr          (mem_addr),
      .mem_wr_data       (mem_wr_data),
      .mem_data_mask     (mem_data_mask),
      .mem_rd_data       (mem_rd_data),
      .mem_rd_data_valid (mem_rd_data_valid),
      .error             (error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk($sformatf("%s_ctl", tag),
          {56'b0, wr_data_next, wr_grant, wr_done, rd_grant, rd_data_valid_o, rd_done, mem_cmd, mem_cmd_en},
          64'd0);
      chk($sformatf("%s_err", tag), 64'(error), 64'd0);
      chk($sformatf("%s_addr", tag), 64'(mem_addr), 64'd0);
      chk($sformatf("%s_wdata", tag), 64'(mem_wr_data), 64'd0);
      chk($sformatf("%s_rdata", tag), 64'(rd_data_o), 64'd0);
      chk($sformatf("%s_mask", tag), 64'(mem_data_mask), 64'd0);
   endtask

   // One full transaction from request to the end of the following gap.
   // got_wr reports what the DUT actually issued (mem_cmd at the strobe).
   task automatic do_txn(input bit w, input bit r, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                         input bit seq_words, input int lat, input bit gappy, input int exp_wait,
                         output bit got_wr);
      logic [DW-1:0] words [BEATS];
      logic [DW-1:0] rdat;
      bit exp_wr, seen, v;
      int waited, got, k;
      for (int i = 0; i < BEATS; i++) words[i] = seq_words ? DW'(i + 1) : DW'($urandom());
      exp_wr = (w && r) ? (starve_m == SLIM) : w;
      wr_addr = wa;
      rd_addr = ra;
      wr_data = words[0];
      wr_req  = w;
      rd_req  = r;
      waited  = 0;
      seen    = 0;
      got_wr  = 1'b0;
      while (!seen && waited < 50) begin
         @(negedge clk);
         waited++;
         seen = mem_cmd_en;
      end
      txn_no++;
      $display("txn %0d: req w=%0b r=%0b expect %s at %h, strobe after %0d cycles",
               txn_no, w, r, exp_wr ? "WRITE" : "READ", exp_wr ? wa : ra, waited);
      chk("cmd_en_seen", 64'(seen), 64'd1);
      if (!seen) begin
         wr_req = 1'b0;
         rd_req = 1'b0;
         return;
      end
      got_wr = mem_cmd;
      if (exp_wait >= 0) chk("cmd_latency", 64'(waited), 64'(exp_wait));
      chk("mem_cmd", 64'(mem_cmd), 64'(exp_wr));
      chk("mem_addr", 64'(mem_addr), 64'(exp_wr ? wa : ra));
      chk("grant", {62'b0, wr_grant, rd_grant}, exp_wr ? 64'd2 : 64'd1);
      if (exp_wr) starve_m = 0;
      else if (w) starve_m = (starve_m < SLIM) ? starve_m + 1 : SLIM;
      if (exp_wr) wr_req = 1'b0;
      else rd_req = 1'b0;

      if (exp_wr) begin
         for (int b = 0; b < BEATS; b++) begin
            if (b > 0) @(negedge clk);
            chk("wr_beat_data", 64'(mem_wr_data), 64'(words[b]));
            chk("wr_beat_flags", {60'b0, wr_grant, wr_data_next, mem_cmd_en, wr_done},
                {60'b0, 1'b1, 1'b1, (b == 0), (b == BEATS - 1)});
            if (b + 1 < BEATS) wr_data = words[b + 1];
         end
         wr_data = DW'($urandom());
      end else begin
         got = 0;
         k = 0;
         while (got < BEATS && k < 300) begin
            @(negedge clk);
            k++;
            v = (k >= lat) && (!gappy || ($urandom_range(0, 2) != 0));
            rdat = DW'($urandom());
            mem_rd_data = rdat;
            mem_rd_data_valid = v;
            #1;
            chk("rd_fwd_valid", 64'(rd_data_valid_o), 64'(v));
            if (v) begin
               chk("rd_fwd_data", 64'(rd_data_o), 64'(rdat));
               got++;
            end
            chk("rd_done", 64'(rd_done), 64'(v && got == BEATS));
            chk("rd_wait_flags", {61'b0, rd_grant, mem_cmd_en, wr_grant}, 64'd4);
         end
         if (got < BEATS) chk("rd_burst_complete", 64'(got), 64'(BEATS));
      end

      for (int g = 1; g <= GAPC; g++) begin
         @(negedge clk);
         mem_rd_data_valid = 1'b0;
         #1;
         chk("gap_strobes",
             {57'b0, mem_cmd_en, mem_cmd, wr_grant, rd_grant, wr_done, rd_done, wr_data_next}, 64'd0);
         chk("gap_addr", 64'(mem_addr), 64'd0);
      end
   endtask

   typedef struct {
      bit w;
      bit r;
      bit exp_wr;
   } arb_vec_t;

   arb_vec_t vecs [9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit g, seen;
      bit order_exp [10];
      int cnt, waited, rise, pat, dones;

      // Starve boundary walk, starting with the counter cleared by a write.
      vecs[0] = '{1'b1, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 1'b0};
      order_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      // Reset state
      repeat (3) @(negedge clk);
      chk_all_zero("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk_all_zero("after_reset");

      // No command before init_done, then a write with words 1..8
      wr_req  = 1'b1;
      wr_addr = 21'h096040;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_cmd_en) cnt++;
      end
      chk("no_cmd_before_init", 64'(cnt), 64'd0);
      init_done = 1'b1;
      do_txn(1'b1, 1'b0, 21'h096040, '0, 1'b1, 1, 1'b0, 2, g);
      init_done = 1'b0;   // later drops are ignored

      // Read at 000100, 8 beats after 5 cycles
      do_txn(1'b0, 1'b1, '0, 21'h000100, 1'b0, 5, 1'b0, 2, g);

      // Both held: R,R,R,R,W,R,R,R,R,W
      for (int i = 0; i < 10; i++) begin
         do_txn(1'b1, 1'b1, AW'($urandom()), AW'($urandom()), 1'b0, $urandom_range(1, 6), 1'b1, 2, g);
         chk($sformatf("grant_order_%0d", i), 64'(g), 64'(order_exp[i]));
      end

      // Arbitration table
      for (int i = 0; i < 9; i++) begin
         do_txn(vecs[i].w, vecs[i].r, AW'($urandom()), AW'($urandom()), 1'b0,
                $urandom_range(1, 6), 1'b1, 2, g);
         chk($sformatf("arb_vec_%0d", i), 64'(g), 64'(vecs[i].exp_wr));
      end

      // Randomized traffic against the model
      for (int i = 0; i < 30; i++) begin
         pat = $urandom_range(1, 3);
         do_txn((pat & 1) != 0, (pat & 2) != 0, AW'($urandom()), AW'($urandom()), 1'b0,
                $urandom_range(1, 8), 1'b1, 2, g);
      end

      // Lost read data: 3 beats only, timeout 64 cycles after the third
      rd_addr = AW'($urandom());
      rd_req  = 1'b1;
      seen = 0;
      waited = 0;
      while (!seen && waited < 50) begin
         @(negedge clk);
         waited++;
         seen = mem_cmd_en;
      end
      $display("txn %0d: short read at %h, 3 beats returned", ++txn_no, rd_addr);
      chk("short_rd_cmd_seen", 64'(seen), 64'd1);
      rd_req = 1'b0;
      dones = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         mem_rd_data_valid = (k >= 5);
         mem_rd_data = DW'($urandom());
         #1;
         if (rd_done) dones++;
      end
      rise = 0;
      for (int j = 1; j <= 70; j++) begin
         @(negedge clk);
         mem_rd_data_valid = 1'b0;
         #1;
         if (rd_done) dones++;
         if (error && rise == 0) rise = j;
      end
      chk("short_rd_no_done", 64'(dones), 64'd0);
      chk("timeout_delay", 64'(rise), 64'd65);
      wr_req = 1'b1;
      rd_req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_cmd_en || wr_grant || rd_grant) cnt++;
      end
      chk("fault_no_cmd", 64'(cnt), 64'd0);
      chk("fault_error_sticky", 64'(error), 64'd1);
      wr_req = 1'b0;
      rd_req = 1'b0;

      // Reset mid-write at beat 4
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      starve_m = 0;
      init_done = 1'b1;
      wr_addr = AW'($urandom());
      wr_data = DW'($urandom());
      wr_req  = 1'b1;
      seen = 0;
      waited = 0;
      while (!seen && waited < 50) begin
         @(negedge clk);
         waited++;
         seen = mem_cmd_en;
      end
      $display("txn %0d: write at %h aborted by reset at beat 4", ++txn_no, wr_addr);
      chk("abort_wr_cmd_seen", 64'(seen), 64'd1);
      wr_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_at_beat4_grant", 64'(wr_grant), 64'd1);
      reset_n = 1'b0;
      init_done = 1'b0;
      #1;
      chk_all_zero("mid_burst_reset");
      @(negedge clk);
      reset_n = 1'b1;
      wr_req = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_cmd_en || wr_done) cnt++;
      end
      chk("post_reset_wait_init", 64'(cnt), 64'd0);
      init_done = 1'b1;
      do_txn(1'b1, 1'b0, AW'($urandom()), '0, 1'b0, 1, 1'b0, 2, g);

      // Stray beat in IDLE: flagged, not forwarded, operation continues
      @(negedge clk);
      chk("stray_pre_error", 64'(error), 64'd0);
      mem_rd_data = DW'($urandom());
      mem_rd_data_valid = 1'b1;
      #1;
      chk("stray_not_fwd", {31'b0, rd_data_valid_o, rd_data_o}, 64'd0);
      @(negedge clk);
      mem_rd_data_valid = 1'b0;
      #1;
      chk("stray_error", 64'(error), 64'd1);
      do_txn(1'b0, 1'b1, '0, AW'($urandom()), 1'b0, 3, 1'b0, -1, g);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
